// File: rtl/pfq_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package pfq_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } pfq_entry_t;

  localparam logic [31:0] PFQ_PC_STEP = 32'd4;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned pfq_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pfq_fifo.sv
// Circular buffer of {pc, inst} entries with occupancy count and synchronous flush.
module pfq_fifo
  import pfq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_flush,
  input  logic                          i_push,
  input  pfq_entry_t                    i_wdata,
  input  logic                          i_pop,
  output pfq_entry_t                    o_rdata,
  output logic                          o_valid,
  output logic [pfq_cnt_w(DEPTH)-1:0]   o_count
);

  localparam int unsigned   PW      = $clog2(DEPTH);
  localparam int unsigned   CW      = pfq_cnt_w(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  pfq_entry_t    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;

  assign w_empty = (r_count == '0);
  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && (w_pop || (r_count != DEPTH_C));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage carries no reset; emptiness masks its contents.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_valid = !w_empty;
  assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: sequential ROM fetch, one-cycle latency absorption, redirect flush.
// Optional starvation counter enabled by defining PFQ_PERF_CNT_EN.
module inst_prefetch_queue
  import pfq_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  output logic [ADDR_W-1:0]             rom_addr,
  output logic                          rom_en,
  input  logic [31:0]                   rom_rdata,
  output logic                          out_valid,
  output logic [31:0]                   out_pc,
  output logic [31:0]                   out_inst,
  input  logic                          out_ready,
  output logic [pfq_cnt_w(DEPTH)-1:0]   count,
  output logic [31:0]                   stall_cnt
);

  localparam int unsigned   CW      = pfq_cnt_w(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic          r_inflight;
  logic [31:0]   r_inflight_pc;
  logic [31:0]   w_issue_pc;
  logic [CW-1:0] w_occ;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  pfq_entry_t    w_wdata;
  pfq_entry_t    w_head;

  assign w_issue_pc = redirect_valid ? (redirect_pc & ~32'd3) : r_fetch_pc;

  // Credit excludes a same-cycle pop so the outstanding response always has a slot.
  assign w_occ   = count + CW'(r_inflight);
  assign w_issue = redirect_valid || (w_occ < DEPTH_C);

  assign rom_en   = resetn && w_issue;
  assign rom_addr = w_issue_pc[ADDR_W+1:2];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc    <= w_issue_pc + PFQ_PC_STEP;
        r_inflight_pc <= w_issue_pc;
      end
    end
  end

  // A response arriving alongside a redirect belongs to the old stream.
  assign w_push       = r_inflight && !redirect_valid;
  assign w_pop        = out_valid && out_ready && !redirect_valid;
  assign w_wdata.pc   = r_inflight_pc;
  assign w_wdata.inst = rom_rdata;

  pfq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_valid (out_valid),
    .o_count (count)
  );

  assign out_pc   = w_head.pc;
  assign out_inst = w_head.inst;

`ifdef PFQ_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
    end else if (out_ready && !out_valid && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed self-checking bench for inst_prefetch_queue with a synchronous ROM model (ROM[i] = i).
module tb_inst_prefetch_queue;

  logic        clk            = 1'b0;
  logic        resetn         = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic [7:0]  rom_addr;
  logic        rom_en;
  logic [31:0] rom_rdata      = '0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready      = 1'b0;
  logic [2:0]  count;
  logic [31:0] stall_cnt;

  logic [31:0] rom [256];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

`ifdef PFQ_PERF_CNT_EN
  localparam logic [31:0] STALL_AFTER_2 = 32'd2;
`else
  localparam logic [31:0] STALL_AFTER_2 = 32'd0;
`endif

  inst_prefetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000),
    .ADDR_W   (8)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_addr       (rom_addr),
    .rom_en         (rom_en),
    .rom_rdata      (rom_rdata),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_ready      (out_ready),
    .count          (count),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_en) rom_rdata <= rom[rom_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance n clock edges; returns 3 time units after the last edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  // Leaves the bench in cycle 0 after release, 4 time units past the edge.
  task automatic apply_reset(input logic rdy);
    resetn         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = rdy;
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = i;

    // 1: reset release, continuous fetch, no bubbles
    apply_reset(1'b1);
    check("rst_count", count, 0);
    check("rst_stall", stall_cnt, 0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin cyc(1); #1; end
      check("t1_rom_addr", rom_addr, k);
      check("t1_rom_en", rom_en, 1);
      if (k >= 2) begin
        check("t1_valid", out_valid, 1);
        check("t1_pc", out_pc, (k - 2) * 4);
        check("t1_inst", out_inst, k - 2);
      end else begin
        check("t1_valid", out_valid, 0);
        check("t1_pc_empty", out_pc, 0);
      end
      if (k == 2) check("t1_stall", stall_cnt, STALL_AFTER_2);
    end

    // 2: back-pressure fills the queue, then drains in order
    apply_reset(1'b0);
    cyc(4); #1;
    check("t2_c4_count", count, 3);
    check("t2_c4_rom_en", rom_en, 0);
    cyc(5); #1;
    check("t2_full_count", count, 4);
    check("t2_full_rom_en", rom_en, 0);
    check("t2_full_pc", out_pc, 0);
    cyc(1); out_ready = 1'b1; #1;
    check("t2_drain_pc0", out_pc, 32'h0);
    check("t2_drain_en0", rom_en, 0);
    for (int j = 1; j < 4; j++) begin
      cyc(1); #1;
      check("t2_drain_pc", out_pc, j * 4);
      if (j == 1) begin
        check("t2_refill_en", rom_en, 1);
        check("t2_refill_addr", rom_addr, 4);
      end
    end
    cyc(1); #1;
    check("t2_next_pc", out_pc, 32'h10);
    check("t2_next_inst", out_inst, 4);

    // 3: redirect with three entries queued
    apply_reset(1'b0);
    cyc(4);
    redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    check("t3_pre_count", count, 3);
    check("t3_rom_addr", rom_addr, 8'h40);
    check("t3_rom_en", rom_en, 1);
    cyc(1); redirect_valid = 1'b0; out_ready = 1'b1; #1;
    check("t3_flushed_count", count, 0);
    check("t3_flushed_valid", out_valid, 0);
    for (int j = 0; j < 3; j++) begin
      cyc(1); #1;
      check("t3_valid", out_valid, 1);
      check("t3_pc", out_pc, 32'h100 + j * 4);
      check("t3_inst", out_inst, 32'h40 + j);
    end

    // 4: back-to-back redirects, only the second target survives
    apply_reset(1'b1);
    cyc(5);
    redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
    check("t4_addr_a", rom_addr, 8'h10);
    cyc(1); redirect_pc = 32'h80; #1;
    check("t4_valid_a", out_valid, 0);
    check("t4_addr_b", rom_addr, 8'h20);
    cyc(1); redirect_valid = 1'b0; #1;
    check("t4_valid_b", out_valid, 0);
    check("t4_addr_seq", rom_addr, 8'h21);
    for (int j = 0; j < 3; j++) begin
      cyc(1); #1;
      check("t4_pc", out_pc, 32'h80 + j * 4);
      check("t4_inst", out_inst, 32'h20 + j);
    end

    // 5: push+pop at count 2, then PC wrap at the top of the address space
    apply_reset(1'b0);
    cyc(3); out_ready = 1'b1; #1;
    check("t5_count_a", count, 2);
    check("t5_pc_a", out_pc, 0);
    cyc(1); #1;
    check("t5_count_b", count, 2);
    check("t5_pc_b", out_pc, 4);
    cyc(1); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    check("t5_wrap_addr", rom_addr, 8'hFF);
    cyc(1); redirect_valid = 1'b0; #1;
    check("t5_wrap_next_addr", rom_addr, 8'h00);
    cyc(1); #1;
    check("t5_top_pc", out_pc, 32'hFFFF_FFFC);
    check("t5_top_inst", out_inst, 32'hFF);
    cyc(1); #1;
    check("t5_wrap_pc", out_pc, 32'h0);
    check("t5_wrap_valid", out_valid, 1);

    // 6: asynchronous reset mid-stream, then restart
    apply_reset(1'b1);
    cyc(5); #1;
    check("t6_pre_valid", out_valid, 1);
    resetn = 1'b0; #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_pc", out_pc, 0);
    check("t6_rst_inst", out_inst, 0);
    check("t6_rst_count", count, 0);
    check("t6_rst_rom_en", rom_en, 0);
    check("t6_rst_rom_addr", rom_addr, 0);
    check("t6_rst_stall", stall_cnt, 0);
    apply_reset(1'b1);
    check("t6_c0_valid", out_valid, 0);
    check("t6_c0_addr", rom_addr, 0);
    cyc(1); #1;
    check("t6_c1_valid", out_valid, 0);
    cyc(1); #1;
    check("t6_c2_pc", out_pc, 0);
    check("t6_c2_inst", out_inst, 0);
    check("t6_c2_stall", stall_cnt, STALL_AFTER_2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
